regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated per-register scoreboard for the pipelined datapath. It provides NUM_RD combinational read ports and two writeback ports, with same-cycle writeback-to-read bypass. A pending-write counter per architectural register lets decode detect RAW hazards and stall on them. Register 0 is hardwired to zero and is never pending.

---
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with writeback bypass and per-register
// pending-write counters for RAW hazard detection.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_pend,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_dest,
  output logic                    iss_ready,
  input  logic                    wb0_en,
  input  logic [AW-1:0]           wb0_dest,
  input  logic [WIDTH-1:0]        wb0_data,
  input  logic                    wb1_en,
  input  logic [AW-1:0]           wb1_dest,
  input  logic [WIDTH-1:0]        wb1_data,
  input  logic                    flush,
  output logic                    err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int SW = CNT_W + 2;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic [1:0]       dec   [DEPTH];
  logic [DEPTH-1:0] hit0, hit1, udf;
  logic [SW-1:0]    sum;
  logic             err_q, err_d;
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      hit0[r] = wb0_en && wb0_dest == AW'(r) && r != 0;
      hit1[r] = wb1_en && wb1_dest == AW'(r) && r != 0;
      dec[r]  = {1'b0, hit0[r]} + {1'b0, hit1[r]};
    end
  end
  // A writeback landing this cycle frees a slot, so a full counter can still accept
  assign iss_ready = flush || iss_dest == '0 || cnt_q[iss_dest] != CNT_MAX ||
                     hit0[iss_dest] || hit1[iss_dest];
  always_comb begin
    sum = '0;
    udf = '0;
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = hit1[r] ? wb1_data : hit0[r] ? wb0_data : mem_q[r];
      sum      = SW'(cnt_q[r]) + SW'(iss_valid && iss_ready && iss_dest == AW'(r) && r != 0);
      udf[r]   = SW'(dec[r]) > sum;
      cnt_d[r] = (flush || udf[r]) ? '0 : CNT_W'(sum - SW'(dec[r]));
    end
    err_d = err_q || (!flush && |udf);
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];
    assign rd_data[i*WIDTH +: WIDTH] = a == '0 ? '0 : hit1[a] ? wb1_data :
                                       hit0[a] ? wb0_data : mem_q[a];
    assign rd_pend[i] = a != '0 && SW'(cnt_q[a]) > SW'(dec[a]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table with a scoreboard queue of expected outputs.
module tb_regfile_sb;
  localparam int W = 32, D = 32, N = 2, AW = 5, NV = 29;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*AW-1:0] rd_addr;
  logic [N*W-1:0]  rd_data;
  logic [N-1:0]    rd_pend;
  logic            iss_valid, iss_ready, wb0_en, wb1_en, flush, err;
  logic [AW-1:0]   iss_dest, wb0_dest, wb1_dest;
  logic [W-1:0]    wb0_data, wb1_data;
  always #5 clk = ~clk;
  regfile_sb #(.WIDTH(W), .DEPTH(D), .NUM_RD(N), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .wb0_en(wb0_en), .wb0_dest(wb0_dest), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_dest(wb1_dest), .wb1_data(wb1_data),
    .flush(flush), .err(err)
  );
  typedef struct {
    logic [AW-1:0] a0, a1;
    logic iv;
    logic [AW-1:0] id;
    logic w0e;
    logic [AW-1:0] w0d;
    logic [W-1:0] w0v;
    logic w1e;
    logic [AW-1:0] w1d;
    logic [W-1:0] w1v;
    logic fl;
    logic [W-1:0] d0;
    logic p0;
    logic [W-1:0] d1;
    logic p1, rdy, er;
  } vec_t;
  typedef struct {
    logic [W-1:0] d0, d1;
    logic p0, p1, rdy, er;
  } exp_t;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t e;
  int checks = 0, errors = 0;
  function automatic vec_t mk(input int a0, a1, iv, id, w0e, w0d, input logic [W-1:0] w0v,
                              input int w1e, w1d, input logic [W-1:0] w1v, input int fl,
                              input logic [W-1:0] d0, input int p0, input logic [W-1:0] d1,
                              input int p1, rdy, er);
    vec_t v;
    v.a0 = AW'(a0); v.a1 = AW'(a1); v.iv = iv[0]; v.id = AW'(id);
    v.w0e = w0e[0]; v.w0d = AW'(w0d); v.w0v = w0v;
    v.w1e = w1e[0]; v.w1d = AW'(w1d); v.w1v = w1v; v.fl = fl[0];
    v.d0 = d0; v.p0 = p0[0]; v.d1 = d1; v.p1 = p1[0]; v.rdy = rdy[0]; v.er = er[0];
    return v;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    rd_addr = {v.a1, v.a0};
    iss_valid = v.iv; iss_dest = v.id;
    wb0_en = v.w0e; wb0_dest = v.w0d; wb0_data = v.w0v;
    wb1_en = v.w1e; wb1_dest = v.w1d; wb1_data = v.w1v;
    flush = v.fl;
    sb.push_back('{d0: v.d0, d1: v.d1, p0: v.p0, p1: v.p1, rdy: v.rdy, er: v.er});
  endtask
  initial begin
    //            a0 a1 iv id w0e w0d w0v           w1e w1d w1v           fl d0            p0 d1            p1 rdy er
    vecs[0]  = mk(0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    vecs[2]  = mk(5, 0, 1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    vecs[3]  = mk(5, 0, 1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 0);
    vecs[4]  = mk(5, 5, 0, 0, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 32'h22222222, 0, 32'h22222222, 0, 1, 0);
    vecs[5]  = mk(5, 5, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h22222222, 0, 32'h22222222, 0, 1, 0);
    vecs[6]  = mk(7, 5, 1, 7, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h22222222, 0, 1, 0);
    vecs[7]  = mk(7, 5, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h22222222, 0, 1, 0);
    vecs[8]  = mk(7, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 32'h0,        0, 32'hA5A5A5A5, 0, 32'h0,        0, 1, 0);
    vecs[9]  = mk(7, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hA5A5A5A5, 0, 32'h0,        0, 1, 0);
    vecs[10] = mk(3, 0, 1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    vecs[11] = mk(3, 0, 1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 0);
    vecs[12] = mk(3, 0, 1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 0);
    vecs[13] = mk(3, 0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 0);
    vecs[14] = mk(3, 0, 1, 3, 1, 3, 32'h33,       0, 0, 32'h0,        0, 32'h33,       1, 32'h0,        0, 1, 0);
    vecs[15] = mk(3, 0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h33,       1, 32'h0,        0, 0, 0);
    vecs[16] = mk(3, 0, 0, 0, 1, 3, 32'h44,       1, 3, 32'h55,       0, 32'h55,       1, 32'h0,        0, 1, 0);
    vecs[17] = mk(3, 0, 0, 0, 0, 0, 32'h0,        1, 3, 32'h66,       0, 32'h66,       0, 32'h0,        0, 1, 0);
    vecs[18] = mk(9, 0, 1, 9, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    vecs[19] = mk(9, 0, 1, 9, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 0);
    vecs[20] = mk(9, 3, 0, 0, 1, 9, 32'h90,       1, 9, 32'h99,       0, 32'h99,       0, 32'h66,       0, 1, 0);
    vecs[21] = mk(9, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h99,       0, 32'h0,        0, 1, 0);
    vecs[22] = mk(4, 0, 1, 4, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    vecs[23] = mk(4, 6, 1, 6, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 0);
    vecs[24] = mk(4, 6, 1, 6, 1, 4, 32'h1,        0, 0, 32'h0,        1, 32'h1,        0, 32'h0,        1, 1, 0);
    vecs[25] = mk(4, 6, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1,        0, 32'h0,        0, 1, 0);
    vecs[26] = mk(6, 0, 0, 0, 1, 6, 32'h6,        0, 0, 32'h0,        0, 32'h6,        0, 32'h0,        0, 1, 0);
    vecs[27] = mk(6, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h6,        0, 32'h0,        0, 1, 1);
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 1);
    rd_addr = '0; iss_valid = 0; iss_dest = '0; flush = 0;
    wb0_en = 0; wb0_dest = '0; wb0_data = '0; wb1_en = 0; wb1_dest = '0; wb1_data = '0;
    #3;
    chk("rst_err", 0, 32'(err), 32'h0);
    chk("rst_rdy", 0, 32'(iss_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      rd_addr = {AW'(i), AW'(D - 1 - i)};
      #1;
      chk("rst_d0", i, rd_data[W-1:0], 32'h0);
      chk("rst_d1", i, rd_data[2*W-1:W], 32'h0);
      chk("rst_pend", i, 32'(rd_pend), 32'h0);
    end
    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      apply(vecs[k]);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_empty", k, 32'h0, 32'h1);
      end else begin
        e = sb.pop_front();
        chk("d0", k, rd_data[W-1:0], e.d0);
        chk("d1", k, rd_data[2*W-1:W], e.d1);
        chk("p0", k, 32'(rd_pend[0]), 32'(e.p0));
        chk("p1", k, 32'(rd_pend[1]), 32'(e.p1));
        chk("rdy", k, 32'(iss_ready), 32'(e.rdy));
        chk("err", k, 32'(err), 32'(e.er));
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd_addr = {AW'(6), AW'(4)};
    #1;
    chk("rerst_err", 0, 32'(err), 32'h0);
    chk("rerst_d0", 0, rd_data[W-1:0], 32'h0);
    chk("rerst_d1", 0, rd_data[2*W-1:W], 32'h0);
    #10;
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
